// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the spi block.
//   - spi_state_e     : transfer state used by both master and slave
//   - DATA_WIDTH_DEF  : default transfer word width
//   - MASTER_WORD_DEF : default word the internal master transmits
//   - SLAVE_WORD_DEF  : default word the internal slave returns
package spi_pkg;

    localparam int         DATA_WIDTH_DEF  = 8;
    localparam logic [7:0] MASTER_WORD_DEF = 8'hA5;
    localparam logic [7:0] SLAVE_WORD_DEF  = 8'h3C;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSFER = 2'd1,
        DONE     = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_slave.sv
// spi_slave: mode-0, MSB-first SPI slave running in the system clock domain.
// Ports:
//   clk   in  system clock, rising edge
//   reset in  asynchronous active-high reset
//   sclk  in  serial clock from the master (registered in clk domain)
//   mosi  in  master-out serial data
//   cs_n  in  active-low chip select
//   miso  out registered slave-out serial data (SLAVE_WORD, MSB first)
// The received word is kept in rx_q and holds until the next transfer starts.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] SLAVE_WORD = DATA_WIDTH'(SLAVE_WORD_DEF)
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic miso
);

    localparam int                 CNT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DATA_WIDTH - 1);

    spi_state_e            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  miso_q, miso_d;

    // Next-state logic: load on select, shift while sclk is high, stop after one word.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        miso_d    = miso_q;
        case (state_q)
            IDLE: begin
                if (!cs_n) begin
                    // MSB goes out right away so it is stable before the first sample edge.
                    state_d   = TRANSFER;
                    bit_cnt_d = CNT_MAX;
                    miso_d    = SLAVE_WORD[DATA_WIDTH-1];
                    tx_d      = {SLAVE_WORD[DATA_WIDTH-2:0], 1'b0};
                    rx_d      = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            TRANSFER: begin
                if (cs_n) begin
                    // Abort: partially received bits are discarded.
                    state_d   = IDLE;
                    bit_cnt_d = CNT_MAX;
                    miso_d    = 1'b0;
                    tx_d      = '0;
                    rx_d      = '0;
                end else if (sclk) begin
                    // This edge ends sclk-high: sample mosi and present the next bit.
                    rx_d = {rx_q[DATA_WIDTH-2:0], mosi};
                    if (bit_cnt_q != '0) begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                        miso_d    = tx_q[DATA_WIDTH-1];
                        tx_d      = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        state_d   = DONE;
                        bit_cnt_d = CNT_MAX;
                        miso_d    = 1'b0;
                    end
                end else begin
                    state_d = TRANSFER;
                end
            end
            DONE: begin
                if (cs_n) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = CNT_MAX;
                miso_d    = 1'b0;
                tx_d      = '0;
                rx_d      = '0;
            end
        endcase
    end

    // Slave state registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= CNT_MAX;
            tx_q      <= '0;
            rx_q      <= '0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            miso_q    <= miso_d;
        end
    end

    assign miso = miso_q;

endmodule

// File: rtl/spi.sv
// spi: internal SPI master linked to an internal spi_slave, mode 0, MSB first.
// Ports:
//   clk             in  system clock, rising edge
//   reset           in  asynchronous active-high reset
//   chip_sel        in  active-low select; low starts/sustains, high aborts/ends
//   master_data_out out registered master MOSI stream
// Each bit takes two clk cycles: phase 0 (sclk low, data valid) then phase 1
// (sclk high). Both sides sample on the edge that ends phase 1. The master's
// received word is kept in rx_q and holds until the next transfer starts.
module spi
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] MASTER_WORD = DATA_WIDTH'(MASTER_WORD_DEF),
    parameter logic [DATA_WIDTH-1:0] SLAVE_WORD  = DATA_WIDTH'(SLAVE_WORD_DEF)
) (
    input  logic clk,
    input  logic reset,
    input  logic chip_sel,
    output logic master_data_out
);

    localparam int               CNT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

    spi_state_e            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  phase_q, phase_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  miso_s;

    // Master next-state logic.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        rx_d      = rx_q;
        case (state_q)
            IDLE: begin
                if (!chip_sel) begin
                    state_d   = TRANSFER;
                    bit_cnt_d = CNT_MAX;
                    phase_d   = 1'b0;
                    sclk_d    = 1'b0;
                    mosi_d    = MASTER_WORD[DATA_WIDTH-1];
                    rx_d      = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            TRANSFER: begin
                if (chip_sel) begin
                    // Abort: drop everything, including the partial receive word.
                    state_d   = IDLE;
                    bit_cnt_d = CNT_MAX;
                    phase_d   = 1'b0;
                    sclk_d    = 1'b0;
                    mosi_d    = 1'b0;
                    rx_d      = '0;
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else begin
                    // End of phase 1: sample miso, then move to next bit or finish.
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                    rx_d    = {rx_q[DATA_WIDTH-2:0], miso_s};
                    if (bit_cnt_q != '0) begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                        mosi_d    = MASTER_WORD[bit_cnt_q - CNT_W'(1)];
                    end else begin
                        state_d   = DONE;
                        bit_cnt_d = CNT_MAX;
                        mosi_d    = 1'b0;
                    end
                end
            end
            DONE: begin
                // Stay quiet until select is released; no second word is sent.
                if (chip_sel) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = CNT_MAX;
                phase_d   = 1'b0;
                sclk_d    = 1'b0;
                mosi_d    = 1'b0;
                rx_d      = '0;
            end
        endcase
    end

    // Master FSM and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= CNT_MAX;
            phase_q   <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            rx_q      <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            rx_q      <= rx_d;
        end
    end

    spi_slave #(
        .DATA_WIDTH (DATA_WIDTH),
        .SLAVE_WORD (SLAVE_WORD)
    ) u_slave (
        .clk   (clk),
        .reset (reset),
        .sclk  (sclk_q),
        .mosi  (mosi_q),
        .cs_n  (chip_sel),
        .miso  (miso_s)
    );

    assign master_data_out = mosi_q;

endmodule

// File: tb/tb_spi.sv
// tb_spi: self-checking bench for spi. A transaction-level reference model
// tracks how many clk edges a transfer has been running and derives the
// expected MOSI bit and the partially received words from that count.
module tb_spi;
    import spi_pkg::*;

    localparam int         DW = 8;
    localparam logic [7:0] MW = 8'hA5;
    localparam logic [7:0] SW = 8'h3C;

    logic clk = 1'b0;
    logic reset;
    logic chip_sel;
    logic master_data_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: age = -1 when no transfer, 0..2*DW-1 while sending, 2*DW when done.
    int         age;
    logic [7:0] held_m;
    logic [7:0] held_s;
    logic [19:0] stream;

    spi #(
        .DATA_WIDTH  (DW),
        .MASTER_WORD (MW),
        .SLAVE_WORD  (SW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .chip_sel        (chip_sel),
        .master_data_out (master_data_out)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_mdo();
        if (age >= 0 && age < 2*DW) return MW[DW-1-age/2];
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_rx(input logic [7:0] word, input logic [7:0] held);
        if (age >= 0) return word >> (DW - age/2);
        return held;
    endfunction

    task automatic model_reset();
        age    = -1;
        held_m = 8'h00;
        held_s = 8'h00;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (age < 0) begin
            if (!chip_sel) age = 0;
        end else if (age < 2*DW) begin
            if (chip_sel) begin
                age    = -1;
                held_m = 8'h00;
                held_s = 8'h00;
            end else begin
                age++;
            end
        end else if (chip_sel) begin
            age    = -1;
            held_m = SW;
            held_s = MW;
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, "_mdo"}, 32'(master_data_out), 32'(exp_mdo()));
        check_val({tag, "_mrx"}, 32'(dut.rx_q), 32'(exp_rx(SW, held_m)));
        check_val({tag, "_srx"}, 32'(dut.u_slave.rx_q), 32'(exp_rx(MW, held_s)));
    endtask

    // One clock cycle: drive inputs (called just after a falling edge), step model, check.
    task automatic step(input logic cs, input logic rst, input string tag);
        chip_sel = cs;
        if (rst && !reset) begin
            reset = 1'b1;
            #1;
            model_reset();
            check_val({tag, "_async_mdo"}, 32'(master_data_out), 32'd0);
            check_val({tag, "_async_state"}, 32'(dut.state_q), 32'(IDLE));
            check_val({tag, "_async_mrx"}, 32'(dut.rx_q), 32'd0);
            check_val({tag, "_async_srx"}, 32'(dut.u_slave.rx_q), 32'd0);
        end else begin
            reset = rst;
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        reset    = 1'b0;
        chip_sel = 1'b1;
        stream   = 20'd0;
        #2 reset = 1'b1;
        model_reset();
        @(negedge clk);
        compare_all("reset_state");

        // Reset held while chip_sel toggles: nothing may come out.
        for (int i = 0; i < 10; i++) step(1'(i % 2), 1'b1, "rst_hold");

        // Full transfer: 20 cycles with chip_sel low, collect the serial stream.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, "full");
            stream = {stream[18:0], master_data_out};
        end
        check_val("full_pattern", 32'(stream), 32'(20'b1100_1100_0011_0011_0000));
        check_val("full_mrx_word", 32'(dut.rx_q), 32'(SW));
        check_val("full_srx_word", 32'(dut.u_slave.rx_q), 32'(MW));

        // Release select; received words must hold.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "release");
        check_val("hold_srx", 32'(dut.u_slave.rx_q), 32'(MW));

        // Abort after three bits (select seen high at E6), then restart from bit7.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "pre_abort");
        step(1'b1, 1'b0, "abort");
        check_val("abort_mdo", 32'(master_data_out), 32'd0);
        step(1'b1, 1'b0, "abort_idle");
        step(1'b0, 1'b0, "restart");
        check_val("restart_bit7", 32'(master_data_out), 32'd1);
        for (int i = 0; i < 19; i++) step(1'b0, 1'b0, "restart_run");
        step(1'b1, 1'b0, "restart_end");

        // Asynchronous reset in the middle of a transfer (after E5).
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "pre_reset");
        step(1'b0, 1'b1, "mid_reset");
        step(1'b0, 1'b1, "mid_reset_hold");
        step(1'b1, 1'b0, "post_reset");

        // Long select: one word only, then constant zero.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, "long_cs");
        check_val("long_mdo_zero", 32'(master_data_out), 32'd0);
        step(1'b1, 1'b0, "long_end");

        // Randomised select runs with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic cs_r;
            logic rst_r;
            cs_r  = ($urandom_range(0, 9) < 2) ? ~chip_sel : chip_sel;
            rst_r = ($urandom_range(0, 59) == 0);
            step(cs_r, rst_r, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi.md
SPI -- requirements
Module: spi

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the transferred word.
REQ-002 Parameter MASTER_WORD, default 8'hA5, fixed word the internal master transmits.
REQ-003 Parameter SLAVE_WORD, default 8'h3C, fixed word the internal slave returns on its MISO line.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 chip_sel  input  1  active-low chip select; low starts and sustains a transfer, high aborts or ends it.
REQ-007 master_data_out  output  1  registered master MOSI bit stream.

Function
REQ-008 The block SHALL contain one SPI master and one SPI slave linked by internal sclk, mosi and miso nets, operating in SPI mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-009 The master state machine SHALL have states IDLE, TRANSFER and DONE.
REQ-010 IDLE: sclk=0, master_data_out=0, bit counter=DATA_WIDTH-1, phase=0; on a rising clk edge with chip_sel=0, go to TRANSFER and drive master_data_out=MASTER_WORD[DATA_WIDTH-1] from that edge.
REQ-011 TRANSFER: each bit SHALL last exactly 2 clk cycles, phase 0 (sclk=0, data valid) then phase 1 (sclk=1).
REQ-012 The slave SHALL sample mosi, and the master SHALL sample miso, at the edge that ends phase 1.
REQ-013 On the edge ending phase 1 with counter>0: decrement the counter and drive the next lower MASTER_WORD bit.
REQ-014 With counter=0: go to DONE and drive master_data_out=0, sclk=0.
REQ-015 For the default width, the edge that samples chip_sel low is E0; bit7 is driven E0..E2, bit6 E2..E4, and so on, bit0 E14..E16; DONE starts at E16.
REQ-016 DONE: hold master_data_out=0 and sclk=0 while chip_sel=0; no retransmission occurs. Go to IDLE on the first edge with chip_sel=1.
REQ-017 chip_sel=1 sampled in TRANSFER SHALL abort: next state IDLE, master_data_out=0, counters cleared, partial receive data discarded.
REQ-018 The slave SHALL shift SLAVE_WORD out on miso, MSB first, changing only at phase-0 starts, and shift received mosi bits into its rx register.
REQ-019 After a full transfer, slave rx register SHALL equal MASTER_WORD and master rx register SHALL equal SLAVE_WORD.
REQ-020 Both rx registers SHALL hold their values until the next transfer starts.
REQ-021 chip_sel is treated as synchronous to clk; no synchronizer is required.

Reset
REQ-022 reset=1 SHALL immediately, without waiting for clk, force: state IDLE, master_data_out=0, sclk=0, counters=DATA_WIDTH-1, phase=0, all shift/rx registers 0.
REQ-023 While reset=1, chip_sel SHALL be ignored.
REQ-024 Reset asserted mid-transfer SHALL abort it with no further bits driven.
REQ-025 After reset deasserts, a transfer SHALL start only on an edge that samples chip_sel=0.

Structure
REQ-026 Package spi_pkg SHALL hold the state enum (IDLE/TRANSFER/DONE), DATA_WIDTH default and MASTER_WORD/SLAVE_WORD defaults.
REQ-027 The slave SHALL be a sub-module spi_slave (ports clk, reset, sclk, mosi, cs_n, miso); the master logic SHALL reside in spi.

Verification
REQ-028 Reset held 1 and chip_sel toggled -> master_data_out stays 0 throughout.
REQ-029 Reset released, chip_sel low for 20 cycles -> master_data_out serial pattern 1,0,1,0,0,1,0,1 (each bit 2 cycles), then 0 for the remaining 4 cycles.
REQ-030 Same transfer -> slave rx = 8'hA5 and master rx = 8'h3C at E16.
REQ-031 chip_sel raised after 3 bits (edge E6) -> output 0 from the next edge; a new chip_sel low restarts from bit7=1.
REQ-032 reset pulsed high at E5 mid-transfer -> master_data_out=0 asynchronously, state IDLE, rx registers 0.
REQ-033 chip_sel held low 40 cycles -> exactly one 8-bit word is output, then constant 0 until chip_sel rises.
